instr_mem_loadable: RTL and testbench
=====================================

# instr_mem_loadable

Loadable instruction memory for the pipelined core, replacing the hard-wired program store. A handshake programming port fills a synchronous RAM at run time. The fetch port reads it with one-cycle latency and a stall input. Any address outside the loaded program returns the architectural NOP.

## Interface
Parameters:
- DATA_W, default 16: instruction word width.
- ADDR_W, default 16: fetch address width (word addressing, not byte addressing).
- DEPTH, default 256: number of storable instruction words; must be ≤ 2^ADDR_W.
- NOP_WORD, default `imem_pkg::NOP_WORD`: word returned for unloaded or out-of-range addresses.

Ports:
- clk, in, 1: single clock; every flop is rising-edge.
- reset, in, 1: asynchronous, active-high.
- fetch_addr, in, ADDR_W: word address of the instruction to fetch.
- fetch_en, in, 1: fetch request; 0 means stall.
- instr, out, DATA_W: fetched instruction (registered).
- instr_valid, out, 1: instr holds a real fetch result from RUN state.
- prog_start, in, 1: one-cycle pulse that enters LOAD and rewinds the write pointer.
- prog_valid, in, 1: prog_data is valid.
- prog_data, in, DATA_W: program word to write.
- prog_ready, out, 1: the block accepts a program word this cycle.
- prog_done, in, 1: one-cycle pulse that ends LOAD.
- loaded, out, 1: a program is present (state is RUN).
- word_count, out, $clog2(DEPTH+1): number of valid program words.

## Operation
- States: EMPTY, LOAD, RUN. Reset enters EMPTY.
- EMPTY → LOAD on prog_start.
- RUN → LOAD on prog_start.
- LOAD → LOAD on prog_start: restart. wr_ptr is set to 0; already-written words remain in the RAM but are not counted.
- LOAD → RUN on prog_done, or automatically after the beat that writes address DEPTH-1.
- Write beat = prog_valid & prog_ready. It writes mem[wr_ptr] and increments wr_ptr.
- prog_ready = (state == LOAD) & (wr_ptr < DEPTH). It is a registered-state decode and does not depend combinationally on prog_valid.
- On entry to RUN, word_count is set to the final wr_ptr, including a write beat in the same cycle as prog_done.
- prog_done outside LOAD is ignored. prog_start and prog_done in the same cycle: prog_start wins.
- Fetch, on a cycle with fetch_en = 1:
  - instr <= mem[fetch_addr] when state is RUN and fetch_addr < word_count; otherwise NOP_WORD.
  - instr_valid <= (state == RUN).
- Fetch, on a cycle with fetch_en = 0: instr and instr_valid hold their values (stall).
- Comparisons are unsigned at full ADDR_W. Address bits above log2(DEPTH) are never truncated, so no aliasing or wrap-around occurs.
- The RAM is not cleared by reset. Contents are unreachable until they are re-loaded and counted.

## Timing
- Reset values:
  - state = EMPTY
  - instr = NOP_WORD
  - instr_valid = 0
  - prog_ready = 0
  - loaded = 0
  - word_count = 0
  - wr_ptr = 0
- Fetch latency is 1 cycle: the address presented at edge N appears on instr after edge N.
- prog_ready rises the cycle after prog_start. A maximum of one word is accepted per cycle.
- loaded rises, and word_count updates, the cycle after prog_done or after the final auto-complete beat.
- A fetch issued in the same cycle as prog_start still uses the pre-edge state, so RUN data is returned. The next fetch returns NOP with instr_valid = 0.
- Reset mid-LOAD or mid-RUN: EMPTY on the next evaluation, with all outputs at their reset values.

## Structure
- Package `imem_pkg`:
  - NOP_WORD constant (encoded equal to ASM_NOP)
  - state enum {EMPTY, LOAD, RUN}
  - COUNT_W helper function
- Sub-module `imem_ram`:
  - DATA_W × DEPTH
  - one synchronous write port and one synchronous read port with read-enable
  - no reset
- Top level: FSM, wr_ptr and word_count counters, range compare, NOP mux on the registered output.

## Test plan
- Reset, then fetch addresses 0 and 5 → instr = NOP_WORD, instr_valid = 0, loaded = 0, word_count = 0.
- Load 19 words (0x1000+i), prog_done on the last beat, then fetch addresses 0, 18 and 19 → 0x1000, 0x1012, NOP; word_count = 19; each result 1 cycle after its address.
- DEPTH = 8 build: stream 10 words → prog_ready drops after the 8th beat, auto RUN, word_count = 8. Fetch address 8 and address 0x0108 → NOP (no aliasing).
- Stall: hold fetch_en = 0 for 3 cycles while fetch_addr changes → instr and instr_valid unchanged. Release fetch_en → new data on the next cycle.
- prog_start from RUN after loading 19 words, reload 4 words → fetch address 10 returns NOP, word_count = 4.
- Boundary cases:
  - Assert reset during the third load beat → EMPTY, prog_ready = 0.
  - Assert prog_start and prog_done in the same cycle → the block stays in LOAD with wr_ptr = 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: NOP encoding,
// load-state encoding and the word-count width helper.
package imem_pkg;

   localparam logic [15:0] ASM_NOP  = 16'hE000;
   localparam logic [15:0] NOP_WORD = ASM_NOP;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } imem_state_e;

   // Enough bits to hold every count from 0 up to and including depth.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Fetch and programming bus of the loadable instruction memory, plus a
// debug view of the load state.
interface instr_mem_loadable_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
);
   import imem_pkg::*;

   localparam int COUNT_W = count_w(DEPTH);

   logic [ADDR_W-1:0]  fetch_addr;
   logic               fetch_en;
   logic [DATA_W-1:0]  instr;
   logic               instr_valid;

   // Programming handshake: a word transfers on every rising edge where
   // prog_valid and prog_ready are both high. prog_ready never depends on
   // prog_valid, and the source may hold or drop prog_valid freely.
   logic               prog_start;
   logic               prog_valid;
   logic [DATA_W-1:0]  prog_data;
   logic               prog_ready;
   logic               prog_done;
   logic               loaded;
   logic [COUNT_W-1:0] word_count;
   imem_state_e        dbg_state;

   modport master (
      output fetch_addr, fetch_en, prog_start, prog_valid, prog_data, prog_done,
      input  instr, instr_valid, prog_ready, loaded, word_count, dbg_state
   );

   modport slave (
      input  fetch_addr, fetch_en, prog_start, prog_valid, prog_data, prog_done,
      output instr, instr_valid, prog_ready, loaded, word_count, dbg_state
   );

endinterface

// File: rtl/imem_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read
// port with read enable. Contents are deliberately not reset.
module imem_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              re,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (re) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: programming FSM, write pointer, word count
// and a one-cycle fetch path that returns NOP outside the loaded program.
module instr_mem_loadable #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 256,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(imem_pkg::NOP_WORD)
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_mem_loadable_if.slave   bus
);
   import imem_pkg::*;

   localparam int COUNT_W = count_w(DEPTH);
   localparam int RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMP_W   = (ADDR_W > COUNT_W) ? ADDR_W : COUNT_W;
   localparam logic [COUNT_W-1:0] LAST_PTR = COUNT_W'(DEPTH - 1);
   localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);

   imem_state_e        state_q, state_d;
   logic [COUNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [COUNT_W-1:0] word_count_q, word_count_d;
   logic               hit_q, hit_d;
   logic               valid_q, valid_d;

   logic               prog_ready;
   logic               write_beat;
   logic               addr_in_range;
   logic [DATA_W-1:0]  ram_rd_data;

   assign prog_ready = (state_q == LOAD) && (wr_ptr_q < DEPTH_C);
   assign write_beat = bus.prog_valid && prog_ready;

   // Full-width unsigned compare so high address bits can never alias.
   assign addr_in_range = CMP_W'(bus.fetch_addr) < CMP_W'(word_count_q);

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      word_count_d = word_count_q;
      case (state_q)
         EMPTY, RUN: begin
            if (bus.prog_start) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
            end
         end
         LOAD: begin
            if (bus.prog_start) begin
               wr_ptr_d = '0;
            end else begin
               if (write_beat) begin
                  wr_ptr_d = wr_ptr_q + COUNT_W'(1);
               end
               if (bus.prog_done || (write_beat && (wr_ptr_q == LAST_PTR))) begin
                  state_d      = RUN;
                  word_count_d = wr_ptr_q + COUNT_W'(write_beat);
               end
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // Fetch result flags; both hold while fetch_en is low, as does the RAM read.
   always_comb begin
      hit_d   = hit_q;
      valid_d = valid_q;
      if (bus.fetch_en) begin
         valid_d = (state_q == RUN);
         hit_d   = (state_q == RUN) && addr_in_range;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= EMPTY;
         wr_ptr_q     <= '0;
         word_count_q <= '0;
         hit_q        <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         word_count_q <= word_count_d;
         hit_q        <= hit_d;
         valid_q      <= valid_d;
      end
   end

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .we      (write_beat),
      .wr_addr (wr_ptr_q[RAM_AW-1:0]),
      .wr_data (bus.prog_data),
      .re      (bus.fetch_en),
      .rd_addr (bus.fetch_addr[RAM_AW-1:0]),
      .rd_data (ram_rd_data)
   );

   assign bus.instr       = hit_q ? ram_rd_data : NOP_WORD;
   assign bus.instr_valid = valid_q;
   assign bus.prog_ready  = prog_ready;
   assign bus.loaded      = (state_q == RUN);
   assign bus.word_count  = word_count_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: a default-depth and a DEPTH=8 instance,
// checked against an array-based model of the load/fetch rules.
module tb_instr_mem_loadable;
   import imem_pkg::*;

   typedef struct packed {
      logic [15:0] instr;
      logic        valid;
   } fetch_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        d_start, d_valid, d_done, d_fen;
   logic [15:0] d_data, d_addr;

   int checks = 0;
   int errors = 0;

   fetch_t exp_q[$];
   fetch_t mon_e;

   imem_state_e m_st;
   int          m_wptr, m_count, m_depth;
   logic [15:0] m_mem [256];
   logic [15:0] m_instr;
   logic        m_valid;

   always #5 clk = ~clk;

   instr_mem_loadable_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) if_a ();
   instr_mem_loadable_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(8))   if_b ();

   assign if_a.fetch_addr = d_addr;
   assign if_a.fetch_en   = d_fen;
   assign if_a.prog_start = d_start & ~sel;
   assign if_a.prog_valid = d_valid & ~sel;
   assign if_a.prog_data  = d_data;
   assign if_a.prog_done  = d_done & ~sel;
   assign if_b.fetch_addr = d_addr;
   assign if_b.fetch_en   = d_fen;
   assign if_b.prog_start = d_start & sel;
   assign if_b.prog_valid = d_valid & sel;
   assign if_b.prog_data  = d_data;
   assign if_b.prog_done  = d_done & sel;

   instr_mem_loadable #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .NOP_WORD(NOP_WORD)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a.slave));
   instr_mem_loadable #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .NOP_WORD(NOP_WORD)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b.slave));

   logic [15:0] a_instr, a_wc;
   logic        a_valid, a_ready, a_loaded;
   logic [1:0]  a_state;
   assign a_instr  = sel ? if_b.instr       : if_a.instr;
   assign a_valid  = sel ? if_b.instr_valid : if_a.instr_valid;
   assign a_ready  = sel ? if_b.prog_ready  : if_a.prog_ready;
   assign a_loaded = sel ? if_b.loaded      : if_a.loaded;
   assign a_wc     = sel ? 16'(if_b.word_count) : 16'(if_a.word_count);
   assign a_state  = sel ? if_b.dbg_state   : if_a.dbg_state;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic status_check();
      chk("prog_ready", 32'(a_ready), 32'((m_st == LOAD) && (m_wptr < m_depth)));
      chk("loaded", 32'(a_loaded), 32'(m_st == RUN));
      chk("word_count", 32'(a_wc), 32'(m_count));
      chk("state", 32'(a_state), 32'(m_st));
   endtask

   // One clock of stimulus: the model consumes the inputs as they stand
   // before the edge, and the fetch result it predicts is queued after it.
   task automatic cycle();
      fetch_t e;
      bit     ready, beat;
      ready = (m_st == LOAD) && (m_wptr < m_depth);
      beat  = d_valid && ready;
      if (d_fen) begin
         m_valid = (m_st == RUN);
         m_instr = NOP_WORD;
         if (m_st == RUN && int'(d_addr) < m_count) m_instr = m_mem[int'(d_addr)];
      end
      if (beat) m_mem[m_wptr] = d_data;
      if (d_start) begin
         m_st   = LOAD;
         m_wptr = 0;
      end else if (m_st == LOAD) begin
         if (beat) m_wptr++;
         if (d_done || (beat && m_wptr == m_depth)) begin
            m_st    = RUN;
            m_count = m_wptr;
         end
      end
      e.instr = m_instr;
      e.valid = m_valid;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      status_check();
   endtask

   task automatic drive(input bit st, input bit v, input logic [15:0] data,
                        input bit dn, input bit fe, input logic [15:0] addr);
      d_start = st; d_valid = v; d_data = data; d_done = dn; d_fen = fe; d_addr = addr;
      cycle();
   endtask

   task automatic fetch(input logic [15:0] addr);
      drive(0, 0, 16'h0, 0, 1, addr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
      d_start = 0; d_valid = 0; d_done = 0; d_fen = 0; d_data = '0; d_addr = '0;
      m_st = EMPTY; m_wptr = 0; m_count = 0; m_instr = NOP_WORD; m_valid = 1'b0;
      #1;
      chk("reset_instr", 32'(a_instr), 32'(NOP_WORD));
      chk("reset_valid", 32'(a_valid), 32'd0);
      status_check();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic load_words(input int n, input logic [15:0] base, input bit done_last);
      drive(1, 0, 16'h0, 0, 0, 16'h0);
      for (int i = 0; i < n; i++) drive(0, 1, base + 16'(i), done_last && (i == n - 1), 0, 16'h0);
      drive(0, 0, 16'h0, 0, 0, 16'h0);
   endtask

   task automatic rand_phase(input int n, input int max_addr);
      for (int i = 0; i < n; i++) begin
         logic [15:0] addr;
         addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, max_addr));
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 16'($urandom),
               $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, addr);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("instr", 32'(a_instr), 32'(mon_e.instr));
         chk("instr_valid", 32'(a_valid), 32'(mon_e.valid));
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      sel = 1'b0; reset = 1'b0; m_depth = 256;
      d_start = 0; d_valid = 0; d_done = 0; d_fen = 0; d_data = '0; d_addr = '0;
      do_reset();
      fetch(16'd0);
      fetch(16'd5);

      // 19-word program, done on the last beat, then edges of the range.
      load_words(19, 16'h1000, 1);
      fetch(16'd0);
      fetch(16'd18);
      fetch(16'd19);

      // Stall with a moving address, then release.
      fetch(16'd3);
      drive(0, 0, 16'h0, 0, 0, 16'd9);
      drive(0, 0, 16'h0, 0, 0, 16'd11);
      drive(0, 0, 16'h0, 0, 0, 16'd12);
      fetch(16'd7);

      // Reload from RUN; the fetch in the prog_start cycle still sees RUN.
      drive(1, 0, 16'h0, 0, 1, 16'd2);
      fetch(16'd2);
      for (int i = 0; i < 4; i++) drive(0, 1, 16'h2000 + 16'(i), i == 3, 0, 16'h0);
      fetch(16'd10);
      fetch(16'd3);

      // prog_start and prog_done together: restart wins.
      drive(1, 0, 16'h0, 0, 0, 16'h0);
      drive(0, 1, 16'h3000, 0, 0, 16'h0);
      drive(0, 1, 16'h3001, 0, 0, 16'h0);
      drive(1, 0, 16'h0, 1, 0, 16'h0);
      for (int i = 0; i < 3; i++) drive(0, 1, 16'h3100 + 16'(i), i == 2, 0, 16'h0);
      for (int i = 0; i < 4; i++) fetch(16'(i));

      // Reset landing on the third load beat.
      drive(1, 0, 16'h0, 0, 0, 16'h0);
      drive(0, 1, 16'h5000, 0, 0, 16'h0);
      drive(0, 1, 16'h5001, 0, 0, 16'h0);
      d_valid = 1; d_data = 16'h5002;
      do_reset();
      fetch(16'd0);

      rand_phase(600, 300);

      // Small-depth instance: auto-complete and no aliasing.
      sel = 1'b1; m_depth = 8;
      do_reset();
      drive(1, 0, 16'h0, 0, 0, 16'h0);
      for (int i = 0; i < 10; i++) drive(0, 1, 16'h4000 + 16'(i), 0, 0, 16'h0);
      fetch(16'd8);
      fetch(16'h0108);
      for (int i = 0; i < 8; i++) fetch(16'(i));
      rand_phase(400, 20);

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
